// File: rtl/alu_pipe.sv
// alu_pipe: two-stage fixed-point ALU with MAC accumulator, post-shift and valid/ready backpressure
// Ports: clk, rst (sync, active-high); op1_i/op2_i signed operands, mode_i op select, valid_i/ready_o input
// handshake; res_o/ovf_o registered result and overflow flag, valid_o/ready_i output handshake.
// Optional build macro ALU_SAT_EN: clamp res_o on overflow instead of wrapping.
module alu_pipe #(
  parameter int Win   = 16,
  parameter int Wout  = 32,
  parameter int Wacc  = 40,
  parameter int SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Win-1:0]  op1_i,
  input  logic [Win-1:0]  op2_i,
  input  logic [2:0]      mode_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [Wout-1:0] res_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            ovf_o
);
  typedef enum logic [2:0] {IDLE, ADD, MULT, SUB, MAC, ACC_CLR, ACC_LD, RSVD} mode_t;
  // one guard bit above the widest of accumulator/result so the range test sees the true sign
  localparam int EW = (Wacc > Wout ? Wacc : Wout) + 1;
  logic                   adv;
  logic [Win-1:0]         s1_op1, s1_op2;
  mode_t                  s1_mode;
  logic                   s1_valid;
  logic [Wacc-1:0]        acc, acc_nxt;
  logic [2*Win-1:0]       p;
  logic signed [EW-1:0]   o1, o2, pe, v, s;
  logic                   ovf;
  logic [Wout-1:0]        res;
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;
  always_comb begin
    o1 = {{(EW-Win){s1_op1[Win-1]}}, s1_op1};
    o2 = {{(EW-Win){s1_op2[Win-1]}}, s1_op2};
    // low 2*Win bits of the product of sign-extended operands equal the signed product
    p  = {{Win{s1_op1[Win-1]}}, s1_op1} * {{Win{s1_op2[Win-1]}}, s1_op2};
    pe = {{(EW-2*Win){p[2*Win-1]}}, p};
    acc_nxt = s1_mode == MAC     ? acc + pe[Wacc-1:0] :
              s1_mode == ACC_CLR ? '0 :
              s1_mode == ACC_LD  ? o1[Wacc-1:0] : acc;
    v = s1_mode == ADD  ? o1 + o2 :
        s1_mode == MULT ? pe :
        s1_mode == SUB  ? o1 - o2 :
        (s1_mode == MAC || s1_mode == ACC_LD) ? {{(EW-Wacc){acc_nxt[Wacc-1]}}, acc_nxt} : '0;
    s = v >>> SHIFT;
    // fits Wout iff every bit from the result sign bit upward agrees
    ovf = |s[EW-1:Wout-1] & ~&s[EW-1:Wout-1];
`ifdef ALU_SAT_EN
    res = ovf ? (s[EW-1] ? {1'b1, {(Wout-1){1'b0}}} : {1'b0, {(Wout-1){1'b1}}}) : s[Wout-1:0];
`else
    res = s[Wout-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= IDLE;
      s1_op1   <= '0;
      s1_op2   <= '0;
      acc      <= '0;
      res_o    <= '0;
      valid_o  <= 1'b0;
      ovf_o    <= 1'b0;
    end else if (adv) begin
      s1_valid <= valid_i;
      s1_mode  <= mode_t'(mode_i);
      s1_op1   <= op1_i;
      s1_op2   <= op2_i;
      valid_o  <= s1_valid;
      if (s1_valid) begin
        acc   <= acc_nxt;
        res_o <= res;
        ovf_o <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized self-checking bench for alu_pipe (three parameterisations)
module tb_alu_pipe;
  logic clk = 0, rst = 1;
  logic signed [15:0] op1_i = 0, op2_i = 0;
  logic [2:0] mode_i = 0;
  logic valid_i = 0, ready_i = 1;
  logic rdy0, rdy1, rdy2, vo0, vo1, vo2, ov0, ov1, ov2;
  logic signed [31:0] res0, res1;
  logic signed [15:0] res2;
  int n_cmp = 0, n_err = 0;
  longint macc = 0;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif

  alu_pipe u0 (.clk(clk), .rst(rst), .op1_i(op1_i), .op2_i(op2_i), .mode_i(mode_i), .valid_i(valid_i),
               .ready_o(rdy0), .res_o(res0), .valid_o(vo0), .ready_i(ready_i), .ovf_o(ov0));
  alu_pipe #(.SHIFT(15)) u1 (.clk(clk), .rst(rst), .op1_i(op1_i), .op2_i(op2_i), .mode_i(mode_i), .valid_i(valid_i),
               .ready_o(rdy1), .res_o(res1), .valid_o(vo1), .ready_i(ready_i), .ovf_o(ov1));
  alu_pipe #(.Wout(16)) u2 (.clk(clk), .rst(rst), .op1_i(op1_i), .op2_i(op2_i), .mode_i(mode_i), .valid_i(valid_i),
               .ready_o(rdy2), .res_o(res2), .valid_o(vo2), .ready_i(ready_i), .ovf_o(ov2));

  always #5 clk = ~clk;

  function automatic longint wrapw(longint x, int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint nres(longint v, int sh, int w);
    longint s = v >>> sh;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    if (SAT && s > hi) return hi;
    if (SAT && s < lo) return lo;
    return wrapw(s, w);
  endfunction

  function automatic bit novf(longint v, int sh, int w);
    longint s = v >>> sh;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    return s > hi || s < -hi - 1;
  endfunction

  task automatic model_beat(input logic [2:0] m, input logic signed [15:0] x, y, output longint v);
    longint a = longint'(x), b = longint'(y);
    v = 0;
    if (m == 1) v = a + b;
    else if (m == 2) v = a * b;
    else if (m == 3) v = a - b;
    else if (m == 4) begin macc = wrapw(macc + a * b, 40); v = macc; end
    else if (m == 5) macc = 0;
    else if (m == 6) begin macc = a; v = a; end
  endtask

  function automatic logic signed [15:0] rnd16();
    int r = $urandom_range(7);
    return r == 0 ? 16'sh8000 : r == 1 ? 16'sh7fff : 16'($urandom);
  endfunction

  task automatic drive(input logic [2:0] m, input int a, b, input logic v);
    mode_i = m; op1_i = 16'(a); op2_i = 16'(b); valid_i = v;
  endtask

  task automatic test_reset;
    rst = 1;
    drive(4, 1234, 567, 1);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (vo0 !== 0 || res0 !== 0 || ov0 !== 0 || vo2 !== 0 || res2 !== 0 || ov2 !== 0) begin
      n_err++; $display("FAIL reset: valid_o=%b res_o=%0d ovf_o=%b (w16 %b/%0d/%b), required 0/0/0", vo0, res0, ov0, vo2, res2, ov2);
    end
    @(negedge clk); rst = 0; drive(0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (vo0 !== 0 || rdy0 !== 1) begin
      n_err++; $display("FAIL reset_release: valid_o=%b ready_o=%b, required 0/1", vo0, rdy0);
    end
  endtask

  task automatic test_add;
    @(negedge clk); drive(1, 100, -300, 1);
    @(negedge clk); drive(0, 0, 0, 0); #1;
    n_cmp++;
    if (vo0 !== 0) begin n_err++; $display("FAIL add_latency: valid_o=%b one cycle after accept, required 0", vo0); end
    @(negedge clk); #1;
    n_cmp++;
    if (vo0 !== 1 || res0 !== -200 || ov0 !== 0) begin
      n_err++; $display("FAIL add: valid_o=%b res_o=%0d ovf_o=%b, required 1/-200/0", vo0, res0, ov0);
    end
  endtask

  task automatic test_mult;
    @(negedge clk); drive(2, -32768, -32768, 1);
    @(negedge clk); drive(0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (vo0 !== 1 || res0 !== 1073741824 || ov0 !== 0) begin
      n_err++; $display("FAIL mult_shift0: valid_o=%b res_o=%0d ovf_o=%b, required 1/1073741824/0", vo0, res0, ov0);
    end
    n_cmp++;
    if (res1 !== 32768 || ov1 !== 0) begin
      n_err++; $display("FAIL mult_shift15: res_o=%0d ovf_o=%b, required 32768/0", res1, ov1);
    end
    n_cmp++;
    if (ov2 !== 1 || res2 !== (SAT ? 16'sd32767 : 16'sd0)) begin
      n_err++; $display("FAIL mult_w16: res_o=%0d ovf_o=%b, required %0d/1", res2, ov2, SAT ? 32767 : 0);
    end
  endtask

  task automatic test_ovf16;
    @(negedge clk); drive(1, 32767, 1, 1);
    @(negedge clk); drive(0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (ov2 !== 1 || res2 !== (SAT ? 16'sd32767 : -16'sd32768)) begin
      n_err++; $display("FAIL ovf_w16: res_o=%0d ovf_o=%b, required %0d/1", res2, ov2, SAT ? 32767 : -32768);
    end
    n_cmp++;
    if (res0 !== 32768 || ov0 !== 0 || res1 !== 1 || ov1 !== 0) begin
      n_err++; $display("FAIL ovf_w32: res_o=%0d/%0d ovf_o=%b/%b, required 32768/1 and 0/0", res0, res1, ov0, ov1);
    end
  endtask

  task automatic test_mac_chain;
    int e[3] = '{5, 17, -3};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) drive(6, 5, 0, 1);
      else if (i == 1) drive(4, 3, 4, 1);
      else if (i == 2) drive(4, -2, 10, 1);
      else drive(0, 0, 0, 0);
      #1;
      if (i >= 2) begin
        n_cmp++;
        if (vo0 !== 1 || res0 !== e[i-2]) begin
          n_err++; $display("FAIL mac_chain[%0d]: valid_o=%b res_o=%0d, required 1/%0d", i - 2, vo0, res0, e[i-2]);
        end
      end
    end
  endtask

  task automatic test_stall;
    int e[4] = '{1, 7, 8, 24};
    int ba[4] = '{1, 2, 1, 4};
    int bb[4] = '{0, 3, 1, 4};
    logic [2:0] bm[4] = '{3'd6, 3'd4, 3'd4, 3'd4};
    int k = 0, r = 0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      ready_i = !(t >= 3 && t <= 5);
      if (k < 4) drive(bm[k], ba[k], bb[k], 1); else drive(0, 0, 0, 0);
      #1;
      if (t >= 3 && t <= 5) begin
        n_cmp++;
        if (rdy0 !== 0 || vo0 !== 1 || res0 !== 7) begin
          n_err++; $display("FAIL stall_hold t=%0d: ready_o=%b valid_o=%b res_o=%0d, required 0/1/7", t, rdy0, vo0, res0);
        end
      end
      if (vo0 && ready_i) begin
        n_cmp++;
        if (r >= 4) begin n_err++; $display("FAIL stall_extra: res_o=%0d, required no further beat", res0); end
        else if (res0 !== e[r]) begin n_err++; $display("FAIL stall_beat[%0d]: res_o=%0d, required %0d", r, res0, e[r]); end
        r++;
      end
      if (valid_i && rdy0) k++;
    end
    ready_i = 1;
    n_cmp++;
    if (r != 4) begin n_err++; $display("FAIL stall_count: beats=%0d, required 4", r); end
  endtask

  task automatic test_rst_mac;
    @(negedge clk); drive(6, 7, 0, 1);
    @(negedge clk); drive(4, 2, 3, 1);
    @(negedge clk); drive(0, 0, 0, 0); rst = 1;
    @(negedge clk); rst = 0; #1;
    n_cmp++;
    if (vo0 !== 0 || res0 !== 0 || ov0 !== 0) begin
      n_err++; $display("FAIL rst_mac: valid_o=%b res_o=%0d ovf_o=%b, required 0/0/0", vo0, res0, ov0);
    end
    drive(4, 1, 1, 1);
    @(negedge clk); drive(0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (vo0 !== 1 || res0 !== 1) begin
      n_err++; $display("FAIL rst_mac_after: valid_o=%b res_o=%0d, required 1/1", vo0, res0);
    end
  endtask

  task automatic test_random;
    longint q[$];
    longint v;
    logic pend = 0;
    rst = 1; drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 0; macc = 0;
    for (int t = 0; t < 410; t++) begin
      @(negedge clk);
      if (t >= 400) begin ready_i = 1; valid_i = 0; end
      else begin
        ready_i = $urandom_range(3) != 0;
        if (!pend) begin
          valid_i = $urandom_range(3) != 0; mode_i = 3'($urandom_range(7));
          op1_i = rnd16(); op2_i = rnd16();
        end
      end
      #1;
      n_cmp++;
      if (rdy0 !== (!vo0 || ready_i)) begin
        n_err++; $display("FAIL rand_ready t=%0d: ready_o=%b, required %b", t, rdy0, !vo0 || ready_i);
      end
      if (vo0 && ready_i) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rand_extra t=%0d: res_o=%0d with no beat pending", t, res0); end
        else begin
          v = q.pop_front();
          if (longint'(res0) !== nres(v, 0, 32) || ov0 !== novf(v, 0, 32)) begin
            n_err++; $display("FAIL rand_u0 t=%0d: res_o=%0d ovf_o=%b, required %0d/%b", t, res0, ov0, nres(v, 0, 32), novf(v, 0, 32));
          end
          n_cmp++;
          if (longint'(res1) !== nres(v, 15, 32) || ov1 !== novf(v, 15, 32)) begin
            n_err++; $display("FAIL rand_u1 t=%0d: res_o=%0d ovf_o=%b, required %0d/%b", t, res1, ov1, nres(v, 15, 32), novf(v, 15, 32));
          end
          n_cmp++;
          if (longint'(res2) !== nres(v, 0, 16) || ov2 !== novf(v, 0, 16)) begin
            n_err++; $display("FAIL rand_u2 t=%0d: res_o=%0d ovf_o=%b, required %0d/%b", t, res2, ov2, nres(v, 0, 16), novf(v, 0, 16));
          end
        end
      end
      if (valid_i && rdy0) begin model_beat(mode_i, op1_i, op2_i, v); q.push_back(v); end
      pend = valid_i && !rdy0;
    end
    n_cmp++;
    if (q.size() != 0) begin n_err++; $display("FAIL rand_lost: %0d beats never emerged, required 0", q.size()); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mult;
    test_ovf16;
    test_mac_chain;
    test_stall;
    test_rst_mac;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Second-generation fixed-point ALU for the EMA filter datapath.
- Two-stage pipelined arithmetic unit with parametrised operand, result and accumulator widths.
- Extended mode set: SUB, MAC with internal accumulator, accumulator clear/load.
- Fixed-point post-shift for Q-format scaling; valid/ready backpressure so the filter controller can stall it.

Parameters:
Win, 16, signed operand width
Wout, 32, signed result width
Wacc, 40, signed accumulator width (must be >= 2*Win)
SHIFT, 0, arithmetic right shift applied to every result before output narrowing (0..2*Win-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
op1_i  in  Win  signed operand 1
op2_i  in  Win  signed operand 2
mode_i  in  3  operation select
valid_i  in  1  input beat valid
ready_o  out  1  unit can accept a beat this cycle
res_o  out  Wout  signed result, registered
valid_o  out  1  res_o valid
ready_i  in  1  downstream accepts res_o
ovf_o  out  1  result did not fit Wout after shift; qualified by valid_o

Behaviour:
- Reset: res_o=0, valid_o=0, ovf_o=0, accumulator=0, stage-1 valid=0, stage-1 mode=IDLE. rst overrides any in-flight beat; in-flight data is discarded.
- Handshake:
  - adv = ~valid_o | ready_i; ready_o = adv (combinational).
  - Input accepted when valid_i & ready_o.
  - When adv=0, both stages and the accumulator hold; res_o, valid_o, ovf_o stay stable.
- Latency: exactly 2 cycles from acceptance to valid_o with ready_i held 1. Full throughput: one beat per cycle.
- Stage 1: registers op1, op2, mode, valid on adv.
- Stage 2: computes full-precision value v; on adv registers res/ovf/valid. Bubbles (stage-1 valid=0) give valid_o=0 and leave the accumulator untouched.
- Modes:
  - 0 IDLE: v=0.
  - 1 ADD: v=op1+op2, Win+1 bits.
  - 2 MULT: v=op1*op2, 2*Win bits.
  - 3 SUB: v=op1-op2, Win+1 bits.
  - 4 MAC: acc<=acc+op1*op2, wrapping at Wacc; v=new acc value.
  - 5 ACC_CLR: acc<=0; v=0.
  - 6 ACC_LD: acc<=sign-extended op1; v=op1.
  - 7: reserved, behaves as IDLE.
- Accumulator changes only on a valid beat in stage 2 while adv=1.
- Back-to-back MACs chain with no hazard: each beat sees the previous beat's result.
- Narrowing:
  - s = v >>> SHIFT, sign-extended to max(Wacc, Wout)+1 bits.
  - ovf = s outside [-2^(Wout-1), 2^(Wout-1)-1].
  - Without ALU_SAT_EN: res = s[Wout-1:0] (wrap).
- Simultaneous MAC and rst: rst wins; acc=0.
- valid_i while ready_o=0: ignored; source must hold.

Optional Feature:
ALU_SAT_EN:
- Defined: when ovf=1, res_o clamps to 2^(Wout-1)-1 (s>0) or -2^(Wout-1) (s<0).
- Undefined: res_o wraps as above.
- ovf_o behaves identically in both builds.

Test Plan:
- Reset, then ADD op1=100, op2=-300, ready_i=1 -> 2 cycles later valid_o=1, res_o=-200, ovf_o=0.
- MULT -32768*-32768, SHIFT=0 -> res_o=1073741824; with SHIFT=15 -> res_o=32768.
- ACC_LD 5, then MAC (3,4), MAC (-2,10) back-to-back -> res_o sequence 5, 17, -3 on consecutive cycles.
- Stream 4 beats, ready_i=0 for 3 cycles after the first output -> ready_o=0 during the stall, res_o held, no beat lost or duplicated, MAC accumulator unchanged during the stall.
- Wout=16, ADD 32767+1 -> ovf_o=1; res_o=-32768 without ALU_SAT_EN, 32767 with it.
- MAC in stage 2 with rst asserted the same cycle -> next cycle valid_o=0, res_o=0, and a subsequent MAC (1,1) returns 1.
